// File: rtl/line_render_scheduler_if.sv
// Request/result handshake between the line render scheduler (master) and the
// shared ray-marcher (slave). Results return in request order.
interface line_render_scheduler_if;
  logic       req_valid;
  logic [9:0] req_x;
  logic [9:0] req_y;
  logic       req_ready;
  logic       res_valid;
  logic [5:0] res_color;

  modport master (
    output req_valid, req_x, req_y,
    input  req_ready, res_valid, res_color
  );

  modport slave (
    input  req_valid, req_x, req_y,
    output req_ready, res_valid, res_color
  );
endinterface

// File: rtl/line_render_scheduler.sv
// Ping-pong line renderer: requests next line's pixels from a shared marcher, displays the previous one.
// Optional macro UNDERRUN_FILL_EN: pixels not rendered by the deadline display magenta instead of stale data.
module line_render_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int MAX_OUT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [10:0]             h_count,
  input  logic [9:0]              v_count,
  line_render_scheduler_if.master mif,
  output logic [5:0]              pix_color,
  output logic                    underrun,
  output logic                    busy
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [10:0]   H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]   H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [XW-1:0] PIX_N    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] PIX_LAST = XW'(H_ACTIVE - 1);
  localparam logic [2:0]    OUT_MAX  = 3'(MAX_OUT);
`ifdef UNDERRUN_FILL_EN
  localparam logic [5:0]    FILL     = 6'b110011;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;

  state_t        state, state_nx;
  logic [5:0]    line_buf [2][H_ACTIVE];
  logic [XW-1:0] done_cnt [2];
  logic          disp_sel, disp_sel_nx, rsel;
  logic [XW-1:0] ptr, ptr_nx;
  logic [9:0]    tgt_y, tgt_y_nx;
  logic [2:0]    outstanding, out_nx;
  logic          pending, pending_nx;
  logic          underrun_nx;
  logic          start_render;

  logic          line_start, start_ok, swap;
  logic [9:0]    line_tgt;
  logic          issue_fire, res_take, res_drop;
  logic [XW-1:0] done_r_nx;
  logic [5:0]    disp_pix;

  assign rsel = ~disp_sel;

  always_comb begin
    line_tgt   = (v_count == V_LAST) ? '0 : v_count + 10'd1;
    line_start = (h_count == '0);
    start_ok   = line_start && (line_tgt < V_ACT);
    swap       = (h_count == H_LAST);
  end

  assign mif.req_valid = (state == ISSUE) && (ptr < PIX_N) && (outstanding < OUT_MAX);
  assign mif.req_x     = 10'(ptr);
  assign mif.req_y     = tgt_y;
  assign busy          = (state == ISSUE) || (state == FLUSH);

  always_comb begin
    issue_fire = mif.req_valid && mif.req_ready;
    res_take   = mif.res_valid && ((state == ISSUE) || (state == WAIT)) &&
                 (outstanding != '0) && (done_cnt[rsel] < PIX_N);
    res_drop   = mif.res_valid && (state == FLUSH) && (outstanding != '0);
    out_nx     = outstanding + 3'(issue_fire) - 3'(res_take || res_drop);
    // Completion count including a result landing on this very edge, so a
    // last-cycle result still counts toward the deadline.
    done_r_nx  = done_cnt[rsel] + XW'(res_take);
  end

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    tgt_y_nx     = tgt_y;
    pending_nx   = pending;
    underrun_nx  = 1'b0;
    start_render = 1'b0;
    disp_sel_nx  = swap ? ~disp_sel : disp_sel;
    if (issue_fire) ptr_nx = ptr + XW'(1);

    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_nx     = ISSUE;
          start_render = 1'b1;
          tgt_y_nx     = line_tgt;
        end
      end
      ISSUE, WAIT: begin
        if (swap) begin
          if (done_r_nx < PIX_N) underrun_nx = 1'b1;
          state_nx = (out_nx != '0) ? FLUSH : IDLE;
        end else if ((state == ISSUE) && issue_fire && (ptr == PIX_LAST)) begin
          state_nx = WAIT;
        end else if ((state == WAIT) && (out_nx == '0)) begin
          state_nx = IDLE;
        end
      end
      FLUSH: begin
        // A line start seen while draining is remembered and launched on exit.
        if (start_ok) begin
          pending_nx = 1'b1;
          tgt_y_nx   = line_tgt;
        end
        if (out_nx == '0) begin
          if (pending_nx) begin
            state_nx     = ISSUE;
            start_render = 1'b1;
            pending_nx   = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
    endcase

    if (start_render) ptr_nx = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      tgt_y       <= '0;
      outstanding <= '0;
      pending     <= 1'b0;
      underrun    <= 1'b0;
      disp_sel    <= 1'b0;
      done_cnt[0] <= '0;
      done_cnt[1] <= '0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      tgt_y       <= tgt_y_nx;
      outstanding <= out_nx;
      pending     <= pending_nx;
      underrun    <= underrun_nx;
      disp_sel    <= disp_sel_nx;
      if (res_take)     done_cnt[rsel] <= done_r_nx;
      if (start_render) done_cnt[~disp_sel_nx] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (res_take) line_buf[rsel][done_cnt[rsel][AW-1:0]] <= mif.res_color;
  end

  always_comb begin
    disp_pix = line_buf[disp_sel][h_count[AW-1:0]];
`ifdef UNDERRUN_FILL_EN
    if (h_count >= 11'(done_cnt[disp_sel])) disp_pix = FILL;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_color <= '0;
    end else if ((h_count < H_ACT) && (v_count < V_ACT)) begin
      pix_color <= disp_pix;
    end else begin
      pix_color <= '0;
    end
  end
endmodule

// File: tb/tb_line_render_scheduler.sv
// Bench for line_render_scheduler: boundary vector table, hand sequences and a
// randomized marcher checked every cycle against a line/queue level model.
module tb_line_render_scheduler;
  localparam int HA = 16;
  localparam int VA = 6;
  localparam int HT = 40;
  localparam int VT = 10;
  localparam int MO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic [5:0]  pix_color;
  logic        underrun, busy;

  line_render_scheduler_if mif();

  line_render_scheduler #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .MAX_OUT(MO)
  ) dut (
    .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count), .mif(mif),
    .pix_color(pix_color), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bench-side raster and marcher
  int hh = 0, vv = 0, cyc = 0;
  int mode = 0;
  int force_rdy = -1;
  bit rst_drv = 1'b1;
  int under_cnt = 0;
  typedef struct { logic [5:0] c; int due; } ret_t;
  ret_t mq[$];

  function automatic bit marcher_ready();
    case (mode)
      0:       return 1'b1;
      1:       return $urandom_range(0, 3) != 0;
      2:       return (cyc % 3) == 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int marcher_lat();
    case (mode)
      0:       return 1;
      1:       return $urandom_range(1, 4);
      2:       return 4;
      default: return 30;
    endcase
  endfunction

  function automatic logic [5:0] color_of(input int x, input int y);
    if (mode == 0) return 6'(x);
    return 6'(x * 7 + y * 13 + 5);
  endfunction

  // Reference model: a render job, the queue of in-flight pixel columns, and two buffers.
  bit         chk_en = 1'b0;
  bit         m_job, m_flush, m_pend;
  int         m_tgt, m_pend_tgt, m_nx, m_disp;
  int         m_q[$];
  int         m_done[2];
  logic [5:0] m_buf[2][HA];
  bit         m_known[2][HA];
  logic [5:0] exp_pix;
  bit         exp_pix_known, exp_under, exp_busy;

  task automatic begin_job(input int t);
    m_job = 1'b1;
    m_tgt = t;
    m_nx  = 0;
    m_done[1 - m_disp] = 0;
  endtask

  task automatic model_reset();
    m_job = 1'b0; m_flush = 1'b0; m_pend = 1'b0;
    m_nx = 0; m_tgt = 0; m_disp = 0;
    m_q.delete();
    m_done[0] = 0; m_done[1] = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < HA; i++) m_known[b][i] = 1'b0;
    exp_pix = '0; exp_pix_known = 1'b1; exp_under = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic cycle();
    bit ev, rdy, rv, fire, start;
    logic [5:0] rc;
    int rs, tgt, x;
    if (chk_en) begin
      if (exp_pix_known) chk("pix_color", pix_color, exp_pix);
      chk("underrun", underrun, exp_under);
      chk("busy", busy, exp_busy);
    end
    if (underrun === 1'b1) under_cnt++;

    h_count = 11'(hh);
    v_count = 10'(vv);
    rst     = rst_drv;
    rdy = (force_rdy >= 0) ? (force_rdy != 0) : marcher_ready();
    rv  = (mq.size() > 0) && (mq[0].due <= cyc);
    rc  = rv ? mq[0].c : 6'($urandom);
    if (rv) void'(mq.pop_front());
    mif.req_ready = rdy;
    mif.res_valid = rv;
    mif.res_color = rc;
    #1;

    ev = m_job && (m_nx < HA) && (m_q.size() < MO);
    if (chk_en) begin
      chk("req_valid", mif.req_valid, ev);
      if (ev) begin
        chk("req_x", mif.req_x, m_nx);
        chk("req_y", mif.req_y, m_tgt);
      end
    end
    fire = ev && rdy;
    if (fire) mq.push_back('{c: color_of(m_nx, m_tgt), due: cyc + marcher_lat()});

    if (rst_drv) begin
      model_reset();
      chk_en = 1'b1;
    end else begin
      rs = 1 - m_disp;
      if (rv && (m_q.size() > 0) && (m_job || m_flush)) begin
        x = m_q.pop_front();
        if (m_job) begin
          m_buf[rs][x] = rc;
          m_known[rs][x] = 1'b1;
          m_done[rs]++;
        end
      end
      if (fire) begin
        m_q.push_back(m_nx);
        m_nx++;
      end

      if (hh < HA && vv < VA) begin
`ifdef UNDERRUN_FILL_EN
        if (hh >= m_done[m_disp]) begin
          exp_pix = 6'b110011; exp_pix_known = 1'b1;
        end else
`endif
        begin
          exp_pix = m_buf[m_disp][hh]; exp_pix_known = m_known[m_disp][hh];
        end
      end else begin
        exp_pix = '0; exp_pix_known = 1'b1;
      end

      exp_under = 1'b0;
      if (hh == HT - 1) begin
        if (m_job && m_done[rs] < HA) begin
          exp_under = 1'b1;
          m_flush = (m_q.size() > 0);
        end
        m_job  = 1'b0;
        m_disp = rs;
      end else if (m_job && m_nx == HA && m_q.size() == 0) begin
        m_job = 1'b0;
      end

      tgt   = (vv == VT - 1) ? 0 : vv + 1;
      start = (hh == 0) && (tgt < VA);
      if (m_flush) begin
        if (start) begin
          m_pend = 1'b1; m_pend_tgt = tgt;
        end
        if (m_q.size() == 0) begin
          m_flush = 1'b0;
          if (m_pend) begin
            m_pend = 1'b0;
            begin_job(m_pend_tgt);
          end
        end
      end else if (!m_job && start) begin
        begin_job(tgt);
      end
      exp_busy = (m_job && m_nx < HA) || m_flush;
    end

    @(posedge clk);
    #1;
    cyc++;
    hh++;
    if (hh == HT) begin
      hh = 0;
      vv = (vv + 1) % VT;
    end
  endtask

  typedef struct { int v; bit exp_valid; int exp_y; bit blank; } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{v: VT - 1, exp_valid: 1'b1, exp_y: 0,      blank: 1'b1};
    tbl[1] = '{v: VA - 1, exp_valid: 1'b0, exp_y: 0,      blank: 1'b0};
    tbl[2] = '{v: 0,      exp_valid: 1'b1, exp_y: 1,      blank: 1'b0};
    tbl[3] = '{v: VA - 2, exp_valid: 1'b1, exp_y: VA - 1, blank: 1'b0};
    tbl[4] = '{v: VA + 1, exp_valid: 1'b0, exp_y: 0,      blank: 1'b1};
    tbl[5] = '{v: VT - 2, exp_valid: 1'b0, exp_y: 0,      blank: 1'b1};

    rst_drv = 1'b1;
    repeat (3) cycle();

    // Line-start target computation from idle
    force_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      rst_drv = 1'b1; hh = 5; vv = tbl[i].v; cycle();
      rst_drv = 1'b0; hh = 0; vv = tbl[i].v; cycle();
      chk("tbl_req_valid", mif.req_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk("tbl_req_y", mif.req_y, tbl[i].exp_y);
      if (tbl[i].blank) chk("tbl_blank_pix", pix_color, 0);
    end

    // Stalled request holds steady, then the outstanding limit caps issue
    rst_drv = 1'b1; hh = HT - 1; vv = VT - 1; cycle();
    rst_drv = 1'b0; mode = 3; cycle();
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", mif.req_valid, 1);
      chk("stall_x", mif.req_x, 0);
      chk("stall_y", mif.req_y, 1);
      cycle();
    end
    force_rdy = 1;
    repeat (MO) cycle();
    chk("max_out_cap", mif.req_valid, 0);
    force_rdy = -1;

    // Fast marcher: every line completes in time
    mode = 0;
    repeat (2 * HT) cycle();
    under_cnt = 0;
    repeat (2 * HT * VT) cycle();
    chk("fast_no_underrun", under_cnt, 0);

    mode = 1;
    repeat (3 * HT * VT) cycle();

    // Slow marcher: deadlines missed, flush and deferred starts
    mode = 2;
    under_cnt = 0;
    repeat (2 * HT * VT) cycle();
    chk("slow_underrun_seen", under_cnt > 0, 1);

    // Reset in the middle of rendering
    for (int i = 0; i < HT * VT && !(vv == 2 && hh == 8); i++) cycle();
    chk("mid_line_busy", busy, 1);
    rst_drv = 1'b1; cycle(); rst_drv = 1'b0;
    chk("rst_req_valid", mif.req_valid, 0);
    chk("rst_req_x", mif.req_x, 0);
    chk("rst_req_y", mif.req_y, 0);
    chk("rst_pix", pix_color, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    mode = 1;
    repeat (2 * HT * VT) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/line_render_scheduler.md
LINE_RENDER_SCHEDULER -- requirements
Module: line_render_scheduler

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter H_TOTAL, default 800, clocks per line.
REQ-004 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-005 SHALL have parameter MAX_OUT, default 4, maximum outstanding marcher requests (1..7).
REQ-006 clk  input  1  pixel clock; only clock.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 h_count  input  11  raster column from timing generator.
REQ-009 v_count  input  10  raster line from timing generator.
REQ-010 req_valid  output  1  pixel request to shared ray-marcher.
REQ-011 req_x  output  10  requested pixel column.
REQ-012 req_y  output  10  requested pixel line.
REQ-013 req_ready  input  1  marcher accepts request.
REQ-014 res_valid  input  1  marcher result strobe; results return in request order.
REQ-015 res_color  input  6  result {r[1:0],g[1:0],b[1:0]}.
REQ-016 pix_color  output  6  display colour {r,g,b}.
REQ-017 underrun  output  1  one-cycle pulse: line missed its deadline.
REQ-018 busy  output  1  high in ISSUE or FLUSH.

Function
REQ-019 SHALL hold two line buffers of H_ACTIVE x 6 bits (ping-pong): one displayed, one rendered, each with a completed-pixel count (done_cnt).
REQ-020 Line start event = h_count==0; target line = 0 if v_count==V_TOTAL-1, else v_count+1; rendering starts only if target < V_ACTIVE.
REQ-021 FSM states: IDLE, ISSUE, WAIT, FLUSH.
REQ-022 IDLE -> ISSUE on valid line start; clears render-buffer done_cnt and issue pointer.
REQ-023 ISSUE: req_valid=1 while issue pointer < H_ACTIVE and outstanding < MAX_OUT; req_x=issue pointer, req_y=target line.
REQ-024 Request transfers when req_valid && req_ready; pointer increments; req_x/req_y SHALL stay stable while req_valid && !req_ready.
REQ-025 ISSUE -> WAIT when last pixel (H_ACTIVE-1) transfers; WAIT -> IDLE when outstanding reaches 0.
REQ-026 Each res_valid writes res_color at render buffer[done_cnt], done_cnt increments; outstanding = issued - returned; simultaneous issue and return leaves it unchanged.
REQ-027 Deadline/swap at h_count==H_TOTAL-1: buffers swap roles every line regardless of state.
REQ-028 If swap occurs in ISSUE or WAIT with done_cnt < H_ACTIVE: underrun pulses the next cycle; with outstanding > 0 go to FLUSH, else IDLE.
REQ-029 FLUSH: req_valid=0; res_valid decrements outstanding, result discarded (no write); -> IDLE at outstanding 0.
REQ-030 Line start arriving while in FLUSH SHALL be deferred: rendering of that target starts the cycle FLUSH exits, same pointer reset as REQ-022.
REQ-031 Display: pix_color registered, latency 1 clock; if h_count < H_ACTIVE and v_count < V_ACTIVE, pix_color = display buffer[h_count], else 6'b000000.
REQ-032 Pixels with x >= displayed buffer's done_cnt handled per REQ-037.
REQ-033 res_valid in IDLE SHALL be ignored.

Reset
REQ-034 While rst=1 at clk edge: state IDLE, req_valid=0, req_x=0, req_y=0, pix_color=0, underrun=0, busy=0, outstanding=0, both done_cnt=0; buffer contents undefined.
REQ-035 Reset mid-line SHALL abort without FLUSH; stray res_valid after reset ignored per REQ-033; first render begins at next valid line start.

Configuration
REQ-036 Macro UNDERRUN_FILL_EN selects handling of unrendered pixels.
REQ-037 Defined: display pixels with x >= done_cnt output 6'b110011 (magenta). Undefined: stale buffer content output, done_cnt ignored for display.

Verification
REQ-038 Marcher ready=1, 1-cycle result latency, res_color=x[5:0]: line y=5 displays pix_color==x[5:0] for x=0..639, one cycle after h_count=x; underrun never pulses.
REQ-039 req_ready low 3 cycles with req_valid high: req_x/req_y stable; outstanding never exceeds 4.
REQ-040 Marcher 2 clocks per pixel: 400 pixels done at deadline -> underrun pulse once; FILL_EN build shows x=400..639 as 6'b110011; FLUSH discards 4 late results; next line renders intact.
REQ-041 v_count=524 line start -> req_y=0; v_count=479 line start -> no requests; blanking pix_color==0.
REQ-042 rst asserted at h_count=300 mid-ISSUE: next clock req_valid=0, pix_color=0, state IDLE; recovery at next line start.
